ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 184 ++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for a
// 5-stage in-order core, with branch flush and hazard stall generation.
// Optional macro FORWARD_EN: adds fwd_a/fwd_b operand-forward selects and
// restricts stalls to load-use; without it every RAW against EX/MEM stalls.
//
// Stage-valid semantics: each stage carries a valid bit. A stage with valid=0
// is a bubble and presents all its control outputs as 0. Every stage advances
// on every clock edge; stall and flush only replace the ID/EX capture with a
// bubble (the upstream PC and IF/ID hold or squash in response).
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       id_ctrl,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_taken,
  output logic             stall,
  output logic             flush,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic             ex_valid,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_valid,
  output logic [REG_W-1:0] mem_rd,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd
`ifdef FORWARD_EN
  ,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`endif
);

  // ID/EX stage: full control bundle plus source and destination indices
  logic             idex_valid, idex_alusrc, idex_memtoreg, idex_regwrite;
  logic             idex_memread, idex_memwrite, idex_branch;
  logic [1:0]       idex_aluop;
  logic [REG_W-1:0] idex_rs1, idex_rs2, idex_rd;

  // EX/MEM stage: memory and writeback controls
  logic             exmem_valid, exmem_memtoreg, exmem_regwrite;
  logic             exmem_memread, exmem_memwrite;
  logic [REG_W-1:0] exmem_rd;

  // MEM/WB stage: writeback controls
  logic             memwb_valid, memwb_regwrite, memwb_memtoreg;
  logic [REG_W-1:0] memwb_rd;

  logic flush_c;
  logic hazard_c;

  // Taken branch resolving in EX squashes the instruction currently in ID
  assign flush_c = idex_valid && idex_branch && ex_taken;

`ifdef FORWARD_EN
  // Only a load in EX cannot be forwarded in time to the next instruction
  assign hazard_c = id_valid && idex_valid && idex_memread &&
                    (idex_rd != '0) &&
                    ((idex_rd == id_rs1) || (idex_rd == id_rs2));

  // Select source for an EX operand: 10 = EX/MEM result, 01 = MEM/WB result
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (exmem_valid && exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs))
      fwd_sel = 2'b10;
    else if (memwb_valid && memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  // Forward selects are held at 00 while reset is asserted
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      fwd_a = fwd_sel(idex_rs1);
      fwd_b = fwd_sel(idex_rs2);
    end
  end
`else
  // Without forwarding, any pending write in EX or MEM to a nonzero source
  // must drain; WB is covered by the write-first register file.
  logic rs1_hit, rs2_hit;
  assign rs1_hit = (id_rs1 != '0) &&
                   ((idex_valid && idex_regwrite && (idex_rd == id_rs1)) ||
                    (exmem_valid && exmem_regwrite && (exmem_rd == id_rs1)));
  assign rs2_hit = (id_rs2 != '0) &&
                   ((idex_valid && idex_regwrite && (idex_rd == id_rs2)) ||
                    (exmem_valid && exmem_regwrite && (exmem_rd == id_rs2)));
  assign hazard_c = id_valid && (rs1_hit || rs2_hit);
`endif

  // Flush wins over stall: the stalled instruction is on the wrong path anyway
  assign flush = rst_n && flush_c;
  assign stall = rst_n && hazard_c && !flush_c;

  // ID/EX capture; a flush or stall inserts a bubble instead of the ID instruction
  always_ff @(posedge clk) begin
    if (!rst_n || flush_c || hazard_c) begin
      idex_valid    <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_branch   <= 1'b0;
      idex_aluop    <= 2'b00;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_rd       <= '0;
    end else begin
      idex_valid    <= id_valid;
      idex_alusrc   <= id_valid & id_ctrl[7];
      idex_memtoreg <= id_valid & id_ctrl[6];
      idex_regwrite <= id_valid & id_ctrl[5];
      idex_memread  <= id_valid & id_ctrl[4];
      idex_memwrite <= id_valid & id_ctrl[3];
      idex_branch   <= id_valid & id_ctrl[2];
      idex_aluop    <= id_ctrl[1:0] & {2{id_valid}};
      idex_rs1      <= id_rs1;
      idex_rs2      <= id_rs2;
      idex_rd       <= id_rd;
    end
  end

  // EX/MEM always advances from ID/EX, including a branch that is flushing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exmem_valid    <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_rd       <= '0;
    end else begin
      exmem_valid    <= idex_valid;
      exmem_memtoreg <= idex_valid & idex_memtoreg;
      exmem_regwrite <= idex_valid & idex_regwrite;
      exmem_memread  <= idex_valid & idex_memread;
      exmem_memwrite <= idex_valid & idex_memwrite;
      exmem_rd       <= idex_rd;
    end
  end

  // MEM/WB always advances from EX/MEM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memwb_valid    <= 1'b0;
      memwb_regwrite <= 1'b0;
      memwb_memtoreg <= 1'b0;
      memwb_rd       <= '0;
    end else begin
      memwb_valid    <= exmem_valid;
      memwb_regwrite <= exmem_valid & exmem_regwrite;
      memwb_memtoreg <= exmem_valid & exmem_memtoreg;
      memwb_rd       <= exmem_rd;
    end
  end

  // Stage outputs: controls gated by their stage valid, indices passed raw
  assign ex_valid     = idex_valid;
  assign ex_alusrc    = idex_valid & idex_alusrc;
  assign ex_aluop     = idex_aluop & {2{idex_valid}};
  assign ex_rs1       = idex_rs1;
  assign ex_rs2       = idex_rs2;
  assign mem_valid    = exmem_valid;
  assign mem_memread  = exmem_valid & exmem_memread;
  assign mem_memwrite = exmem_valid & exmem_memwrite;
  assign mem_rd       = exmem_rd;
  assign wb_valid     = memwb_valid;
  assign wb_regwrite  = memwb_valid & memwb_regwrite;
  assign wb_memtoreg  = memwb_valid & memwb_memtoreg;
  assign wb_rd        = memwb_rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe. Builds with or without
// FORWARD_EN; scenarios specific to one configuration are selected by it.
module tb_ctrl_pipe;

  localparam int REG_W = 5;

  // per-cycle expectation: {cyc[31:0], mask[4:0], stall, flush, ex_valid, fwd_a, fwd_b}
  localparam int CW = 44;
  // writeback expectation: {cyc[31:0], regwrite, memtoreg, rd[4:0]}
  localparam int W = 39;

  localparam logic [7:0] RT = 8'b0010_0010;  // R-type ALU op
  localparam logic [7:0] LD = 8'b1111_0000;  // load
  localparam logic [7:0] BR = 8'b0000_0101;  // branch
  localparam logic [7:0] LB = 8'b1111_0101;  // load+branch, to collide flush with load-use

  localparam logic [4:0] M_S = 5'b00001;
  localparam logic [4:0] M_F = 5'b00010;
  localparam logic [4:0] M_E = 5'b00100;
  localparam logic [4:0] M_W = 5'b01000;
  localparam logic [4:0] M_Z = 5'b10000;
  localparam logic [4:0] SF  = M_S | M_F;
  localparam logic [4:0] SFE = M_S | M_F | M_E;

  logic             clk;
  logic             rst_n;
  logic [7:0]       id_ctrl;
  logic             id_valid;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             ex_taken;
  logic             stall, flush;
  logic             ex_alusrc;
  logic [1:0]       ex_aluop;
  logic [REG_W-1:0] ex_rs1, ex_rs2;
  logic             ex_valid;
  logic             mem_memread, mem_memwrite, mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic             wb_regwrite, wb_memtoreg, wb_valid;
  logic [REG_W-1:0] wb_rd;
`ifdef FORWARD_EN
  logic [1:0]       fwd_a, fwd_b;
`endif

  logic [31:0]   cyc;
  int            n_cmp;
  int            n_bad;
  logic [CW-1:0] chk_q[$];
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] rec;
  logic [W-1:0]  wrec;

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
    .stall(stall), .flush(flush), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_valid(ex_valid),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
`ifdef FORWARD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // driver: one cycle of ID inputs plus the hand-computed expectations for it
  task automatic step(input logic v, input logic [7:0] c, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd, input logic tk,
                      input logic rs, input logic cap, input logic [4:0] mask,
                      input logic e_st, input logic e_fl, input logic e_exv,
                      input logic [3:0] e_fwd);
    @(posedge clk);
    #1;
    rst_n    = rs;
    id_valid = v;
    id_ctrl  = c;
    id_rs1   = r1;
    id_rs2   = r2;
    id_rd    = rd;
    ex_taken = tk;
    chk_q.push_back({cyc, mask, e_st, e_fl, e_exv, e_fwd});
    if (cap) exp_q.push_back({cyc + 32'd3, c[5], c[6], rd});
  endtask

  task automatic idle(input logic [4:0] mask, input logic e_exv, input logic [3:0] e_fwd);
    step(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mask, 1'b0, 1'b0, e_exv, e_fwd);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) idle(SF, 1'b0, 4'h0);
  endtask

  // monitor: per-cycle control checks and writeback scoreboard
  always @(negedge clk) begin
    if (chk_q.size() > 0 && chk_q[0][43:12] == cyc) begin
      rec = chk_q.pop_front();
      if (rec[7])  chk("stall", {63'd0, stall}, {63'd0, rec[6]});
      if (rec[8])  chk("flush", {63'd0, flush}, {63'd0, rec[5]});
      if (rec[9])  chk("ex_valid", {63'd0, ex_valid}, {63'd0, rec[4]});
`ifdef FORWARD_EN
      if (rec[10]) chk("fwd_ab", {60'd0, fwd_a, fwd_b}, {60'd0, rec[3:0]});
`endif
      if (rec[11])
        chk("all_zero", {32'd0, ex_alusrc, ex_aluop, ex_rs1, ex_rs2, ex_valid,
                         mem_memread, mem_memwrite, mem_valid, mem_rd,
                         wb_regwrite, wb_memtoreg, wb_valid, wb_rd, stall, flush},
            64'd0);
    end
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected cyc=%0d got rd=%0d regwrite=%b exp no writeback",
                 cyc, wb_rd, wb_regwrite);
      end else begin
        wrec = exp_q.pop_front();
        chk("wb_cycle", {32'd0, cyc}, {32'd0, wrec[38:7]});
        chk("wb_regwrite", {63'd0, wb_regwrite}, {63'd0, wrec[6]});
        chk("wb_memtoreg", {63'd0, wb_memtoreg}, {63'd0, wrec[5]});
        chk("wb_rd", {59'd0, wb_rd}, {59'd0, wrec[4:0]});
      end
    end else begin
      chk("wb_gated", {62'd0, wb_regwrite, wb_memtoreg}, 64'd0);
    end
  end

  // watchdog
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog cyc=%0d got no end of stimulus exp finish", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // stimulus
  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; id_valid = 1'b0; id_ctrl = 8'h00;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_taken = 1'b0;

    // reset, then one R-type writing x5
    step(0, 8'h00, 0, 0, 0, 0, 0, 0, SFE | M_W, 0, 0, 0, 4'h0);
    step(0, 8'h00, 0, 0, 0, 0, 1, 0, SFE | M_W | M_Z, 0, 0, 0, 4'h0);
    step(1, RT, 1, 2, 5, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    idle(SFE, 1, 4'h0);
    idle(SFE, 0, 4'h0);
    idle(SFE, 0, 4'h0);
    gap(2);

    // taken branch flushes ID; not-taken does not; flush beats load-use stall
    step(1, BR, 1, 2, 0, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 1, 2, 13, 1, 1, 0, SFE, 0, 1, 1, 4'h0);
    idle(SFE, 0, 4'h0);
    step(1, BR, 1, 2, 0, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 1, 2, 13, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    idle(SFE, 1, 4'h0);
    step(1, LB, 1, 2, 3, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 3, 0, 14, 1, 1, 0, SFE, 0, 1, 1, 4'h0);
    idle(SFE, 0, 4'h0);
    gap(3);

    // reset with all three stages full: x5 retires, x6/x7 are discarded
    step(1, RT, 1, 2, 5, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 1, 2, 6, 0, 1, 0, SFE, 0, 0, 1, 4'h0);
    step(1, RT, 1, 2, 7, 0, 1, 0, SFE, 0, 0, 1, 4'h0);
    step(0, 8'h00, 0, 0, 0, 0, 0, 0, SFE | M_W, 0, 0, 1, 4'h0);
    step(0, 8'h00, 0, 0, 0, 0, 1, 0, SFE | M_W | M_Z, 0, 0, 0, 4'h0);
    gap(4);

`ifdef FORWARD_EN
    // load-use on rs1: one stall, bubble in EX, then WB forward
    step(1, LD, 1, 2, 3, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 3, 0, 6, 0, 1, 0, SFE | M_W, 1, 0, 1, 4'h0);
    step(1, RT, 3, 0, 6, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    idle(SFE | M_W, 1, 4'b0100);
    gap(3);
    // load-use on rs2; load to x0 never stalls
    step(1, LD, 1, 2, 9, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 0, 9, 6, 0, 1, 0, SFE, 1, 0, 1, 4'h0);
    step(1, RT, 0, 9, 6, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    idle(SFE, 1, 4'h0);
    step(1, LD, 1, 2, 0, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 0, 0, 6, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    gap(4);
    // ALU back-to-back: MEM forward, x0 never forwarded, MEM beats WB
    step(1, RT, 1, 2, 4, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 4, 0, 8, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    idle(SFE | M_W, 1, 4'b1000);
    step(1, RT, 1, 2, 0, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 0, 0, 9, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    idle(SFE | M_W, 1, 4'b0000);
    step(1, RT, 1, 2, 10, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 0, 10, 11, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    idle(SFE | M_W, 1, 4'b0010);
    step(1, RT, 1, 2, 12, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 1, 2, 12, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    step(1, RT, 12, 12, 13, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    idle(SFE | M_W, 1, 4'b1010);
`else
    // RAW on x7 stalls while the producer is in EX and MEM
    step(1, RT, 1, 2, 7, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 7, 0, 15, 0, 1, 0, SFE, 1, 0, 1, 4'h0);
    step(1, RT, 7, 0, 15, 0, 1, 0, SFE, 1, 0, 0, 4'h0);
    step(1, RT, 7, 0, 15, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    idle(SFE, 1, 4'h0);
    // x0 producer/consumer never stalls; rs2 RAW also stalls
    step(1, RT, 1, 2, 0, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
    step(1, RT, 0, 0, 16, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    step(1, RT, 1, 2, 9, 0, 1, 1, SFE, 0, 0, 1, 4'h0);
    step(1, RT, 0, 9, 17, 0, 1, 0, SFE, 1, 0, 1, 4'h0);
    step(1, RT, 0, 9, 17, 0, 1, 0, SFE, 1, 0, 0, 4'h0);
    step(1, RT, 0, 9, 17, 0, 1, 1, SFE, 0, 0, 0, 4'h0);
`endif
    gap(5);
    @(negedge clk);
    #1;

    chk("wb_queue_left", {32'd0, exp_q.size()}, 64'd0);
    chk("chk_queue_left", {32'd0, chk_q.size()}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
